// File: rtl/vram_pkg.sv
// Shared VRAM types and constants for the arbiter, pixel fetch unit and bus bridge.
package vram_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   localparam int VRAM_RD_LAT = 1;
   localparam int VRAM_ADDR_W = 15;
   localparam int VRAM_DATA_W = 14;

endpackage

// File: rtl/vram_rd_pipe.sv
// Owner-tag shift pipe tracking in-flight reads, plus per-port read-return registers.
module vram_rd_pipe
   import vram_pkg::*;
#(
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  owner_t            owner_in,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata
);

   // One stage for the command register plus the RAM read latency.
   localparam int PIPE_D = VRAM_RD_LAT + 1;

   owner_t tag_q [PIPE_D];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PIPE_D; i++) tag_q[i] <= OWN_NONE;
         disp_rvalid <= 1'b0;
         disp_rdata  <= '0;
         cpu_rvalid  <= 1'b0;
         cpu_rdata   <= '0;
      end else begin
         tag_q[0] <= owner_in;
         for (int i = 1; i < PIPE_D; i++) tag_q[i] <= tag_q[i-1];
         // Last tag lines up with mem_rdata; rdata holds between returns.
         disp_rvalid <= (tag_q[PIPE_D-1] == OWN_DISP);
         cpu_rvalid  <= (tag_q[PIPE_D-1] == OWN_CPU);
         if (tag_q[PIPE_D-1] == OWN_DISP) disp_rdata <= mem_rdata;
         if (tag_q[PIPE_D-1] == OWN_CPU)  cpu_rdata  <= mem_rdata;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Display-priority arbiter for the single-port framebuffer RAM with a CPU starvation bound.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_ack,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             starved;
   owner_t           owner_in;

   assign starved = (wait_cnt >= CNT_W'(STARVE_LIMIT));

   // Handshake: a request is taken in the cycle its ack is high; the
   // requester holds req and payload stable until then. Acks are mutually exclusive.
   always_comb begin
      disp_ack = 1'b0;
      cpu_ack  = 1'b0;
      if (!reset) begin
         if (cpu_req && (!disp_req || starved)) cpu_ack  = 1'b1;
         else if (disp_req)                     disp_ack = 1'b1;
      end
   end

   always_comb begin
      owner_in = OWN_NONE;
      if (disp_ack)                owner_in = OWN_DISP;
      else if (cpu_ack && !cpu_we) owner_in = OWN_CPU;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!cpu_req || cpu_ack) begin
         wait_cnt <= '0;
      end else if (!starved) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Address and write data hold across idle cycles; only we is forced low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= disp_ack | cpu_ack;
         mem_we <= 1'b0;
         if (disp_ack) begin
            mem_addr  <= disp_addr;
            mem_wdata <= '0;
         end else if (cpu_ack) begin
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_we ? cpu_wdata : '0;
         end
      end
   end

   vram_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk         (clk),
      .reset       (reset),
      .owner_in    (owner_in),
      .mem_rdata   (mem_rdata),
      .disp_rvalid (disp_rvalid),
      .disp_rdata  (disp_rdata),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata)
   );

endmodule
